riscv_dmem_responder: RTL and testbench
=======================================

// Module: riscv_dmem_responder
// PURPOSE
//  Responder on the RV32 core's data-memory port (MemWriteM/ALUResultM/WriteDataM/ReadDataM).
//  Holds word RAM plus an MMIO window: 64-bit cycle counter, timer compare with IRQ, byte TX FIFO
//  drained over a valid/ready stream. Sits beside the core at top level; core sees no wait states.
// PARAMETERS
//  DEPTH_WORDS  1024          RAM size in 32-bit words (power of 2)
//  FIFO_DEPTH   8             TX FIFO entries (power of 2, >=2)
//  MMIO_BASE    32'h8000_0000 base of 16-byte MMIO window
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   asynchronous, active-high reset
//  MemWriteM    in   1   store strobe from core M stage
//  ALUResultM   in   32  byte address from core
//  WriteDataM   in   32  store data
//  ReadDataM    out  32  load data, combinational from ALUResultM
//  tx_valid     out  1   FIFO head valid
//  tx_data      out  8   FIFO head byte
//  tx_ready     in   1   sink accepts head when tx_valid&tx_ready
//  timer_irq    out  1   level IRQ, set on compare match
//  bus_error    out  1   registered 1-cycle pulse on bad access
// BEHAVIOUR
//  Reset: cycle=0, timecmp=32'hFFFF_FFFF, FIFO empty (tx_valid=0, tx_data=0), timer_irq=0,
//   bus_error=0, overflow=0. RAM contents not reset. ReadDataM follows address even in reset.
//  Decode: word index = ALUResultM[31:2]; ALUResultM[1:0]!=0 -> misaligned.
//   RAM: addr < 4*DEPTH_WORDS. MMIO: addr in [MMIO_BASE, MMIO_BASE+15]. Else unmapped.
//  Loads: 0-cycle latency, combinational. Unmapped/misaligned read -> ReadDataM=0.
//  Stores: commit at rising edge when MemWriteM=1; full-word only. Unmapped/misaligned store
//   ignored. bus_error asserts the cycle after any misaligned or unmapped access
//   (read decode counted only when MemWriteM=1 or addr is misaligned; core has no load strobe).
//  MMIO map (offset):
//   0x0 CYCLE_LO RO  cycle[31:0]; increments every clk, wraps 2^64 -> 0
//   0x4 CYCLE_HI RO  cycle[63:32]
//   0x8 TIMECMP  RW  write loads value and clears timer_irq same edge
//   0xC TX       W: push WriteDataM[7:0]; R: {29'b0, overflow, full, empty}
//   Writes to RO offsets ignored, no bus_error.
//  Timer: timer_irq set at edge where cycle[31:0]==timecmp; held until TIMECMP write.
//   Write to TIMECMP on the same edge as a match: write wins (irq cleared).
//  FIFO: push on TX store; pop on tx_valid&tx_ready. tx_data = head entry, stable while
//   tx_valid&!tx_ready. Push to empty FIFO: tx_valid rises next cycle (no bypass).
//   Push when full and no pop same cycle: byte dropped, overflow sticky (cleared only by reset).
//   Push when full with pop same cycle: accepted, count unchanged. Pointers wrap mod FIFO_DEPTH.
//  Reset mid-operation: FIFO contents discarded, in-flight store lost, outputs to reset values.
// TESTING
//  1 SW 0xDEADBEEF @0x10, then address 0x10 -> ReadDataM=0xDEADBEEF same cycle; @0x14 unchanged.
//  2 Store 9 bytes 0x41..0x49 to TX with tx_ready=0, FIFO_DEPTH=8 -> status=0b110 (ovf,full);
//    raise tx_ready -> 0x41..0x48 emitted in order, 0x49 absent, status=0b101.
//  3 Full FIFO, tx_ready=1 and TX store same cycle -> store accepted, full stays 1, no overflow.
//  4 Write TIMECMP=cycle_lo+20 -> timer_irq rises exactly 20 edges later; TIMECMP write clears it.
//  5 Access 0x0000_0002 (store) and 0x4000_0000 (store) -> each 1-cycle bus_error, RAM unchanged,
//    ReadDataM=0.
//  6 Assert reset asynchronously mid-drain -> tx_valid=0, timer_irq=0, CYCLE_LO reads 0 without clk edge.

Source files
------------

// File: rtl/riscv_dmem_responder.sv
// -----------------------------------------------------------------------------
// riscv_dmem_responder
//
// Data-memory responder for the RV32 core's M-stage port. It answers every
// access with zero wait states and holds:
//   - a word-addressed RAM (DEPTH_WORDS x 32 bit, contents never reset)
//   - a 16-byte MMIO window at MMIO_BASE:
//       +0x0 CYCLE_LO  RO  free-running 64-bit cycle counter, low word
//       +0x4 CYCLE_HI  RO  cycle counter, high word
//       +0x8 TIMECMP   RW  compare value; a write also clears timer_irq
//       +0xC TX        W: push WriteDataM[7:0]  R: {29'b0, overflow, full, empty}
//
// Ports
//   clk         in   1   clock, all state changes on the rising edge
//   reset       in   1   asynchronous, active-high reset
//   MemWriteM   in   1   store strobe from the core
//   ALUResultM  in   32  byte address from the core
//   WriteDataM  in   32  store data
//   ReadDataM   out  32  load data, combinational from ALUResultM
//   tx_valid    out  1   TX FIFO head valid
//   tx_data     out  8   TX FIFO head byte (0 while empty)
//   tx_ready    in   1   sink takes the head when tx_valid & tx_ready
//   timer_irq   out  1   level interrupt, set on CYCLE_LO == TIMECMP
//   bus_error   out  1   registered pulse after a misaligned/unmapped access
// -----------------------------------------------------------------------------
module riscv_dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        timer_irq,
   output logic        bus_error
);

   localparam int unsigned RAM_AW  = $clog2(DEPTH_WORDS);
   localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);

   localparam logic [31:0]        RAM_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [31:0]        MMIO_SPAN = 32'd16;
   localparam logic [FIFO_AW:0]   CNT_ZERO  = (FIFO_AW + 1)'(0);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(FIFO_DEPTH);
   localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);

   localparam logic [3:0] OFF_CYCLE_LO = 4'h0;
   localparam logic [3:0] OFF_CYCLE_HI = 4'h4;
   localparam logic [3:0] OFF_TIMECMP  = 4'h8;
   localparam logic [3:0] OFF_TX       = 4'hC;

   // state
   logic [31:0]        ram_r      [DEPTH_WORDS];
   logic [7:0]         fifoMem_r  [FIFO_DEPTH];
   logic [63:0]        cycle_r;
   logic [31:0]        timecmp_r;
   logic               timerIrq_r;
   logic               busError_r;
   logic               overflow_r;
   logic [FIFO_AW:0]   count_r;
   logic [FIFO_AW-1:0] rdPtr_r;
   logic [FIFO_AW-1:0] wrPtr_r;
   logic               txValid_r;
   logic [7:0]         txData_r;

   // decode / next-state signals
   logic [31:0]        mmioOff_s;
   logic [RAM_AW-1:0]  ramIdx_s;
   logic               misaligned_s;
   logic               isRam_s;
   logic               isMmio_s;
   logic               ramWe_s;
   logic               cmpWe_s;
   logic               push_s;
   logic               badAccess_s;
   logic               full_s;
   logic               empty_s;
   logic               pop_s;
   logic               accept_s;
   logic               drop_s;
   logic [FIFO_AW:0]   countNext_s;
   logic [FIFO_AW:0]   countAfterPop_s;
   logic [FIFO_AW-1:0] rdPtrNext_s;
   logic [7:0]         headNext_s;
   logic [31:0]        readData_s;

   // Address decode and store strobes. RAM wins if the two regions ever overlap.
   always_comb begin
      mmioOff_s    = ALUResultM - MMIO_BASE;
      ramIdx_s     = ALUResultM[RAM_AW+1:2];
      misaligned_s = (ALUResultM[1:0] != 2'b00);
      isRam_s      = (ALUResultM < RAM_BYTES);
      isMmio_s     = !isRam_s && (mmioOff_s < MMIO_SPAN);
      ramWe_s      = MemWriteM && !misaligned_s && isRam_s;
      cmpWe_s      = MemWriteM && !misaligned_s && isMmio_s && (mmioOff_s[3:0] == OFF_TIMECMP);
      push_s       = MemWriteM && !misaligned_s && isMmio_s && (mmioOff_s[3:0] == OFF_TX);
      // The core has no load strobe, so an unmapped address only counts as
      // an access when it is stored to; misalignment is always an error.
      badAccess_s  = misaligned_s || (MemWriteM && !isRam_s && !isMmio_s);
   end

   // FIFO occupancy, push/pop arbitration and the head byte after this edge.
   always_comb begin
      full_s          = (count_r == CNT_FULL);
      empty_s         = (count_r == CNT_ZERO);
      pop_s           = txValid_r && tx_ready;
      // A pop in the same cycle frees the slot a full-FIFO push needs.
      accept_s        = push_s && (!full_s || pop_s);
      drop_s          = push_s && full_s && !pop_s;
      rdPtrNext_s     = pop_s ? (rdPtr_r + PTR_ONE) : rdPtr_r;
      countAfterPop_s = pop_s ? (count_r - CNT_ONE) : count_r;
      if (accept_s && !pop_s) begin
         countNext_s = count_r + CNT_ONE;
      end else if (!accept_s && pop_s) begin
         countNext_s = count_r - CNT_ONE;
      end else begin
         countNext_s = count_r;
      end
      // If nothing old survives the pop, the new head is the byte being pushed.
      if (countNext_s == CNT_ZERO) begin
         headNext_s = 8'h00;
      end else if (countAfterPop_s == CNT_ZERO) begin
         headNext_s = WriteDataM[7:0];
      end else begin
         headNext_s = fifoMem_r[rdPtrNext_s];
      end
   end

   // Zero-latency load mux; misaligned and unmapped reads return zero.
   always_comb begin
      readData_s = 32'h0000_0000;
      if (misaligned_s) begin
         readData_s = 32'h0000_0000;
      end else if (isRam_s) begin
         readData_s = ram_r[ramIdx_s];
      end else if (isMmio_s) begin
         case (mmioOff_s[3:0])
            OFF_CYCLE_LO: readData_s = cycle_r[31:0];
            OFF_CYCLE_HI: readData_s = cycle_r[63:32];
            OFF_TIMECMP:  readData_s = timecmp_r;
            OFF_TX:       readData_s = {29'b0, overflow_r, full_s, empty_s};
            default:      readData_s = 32'h0000_0000;
         endcase
      end else begin
         readData_s = 32'h0000_0000;
      end
   end

   // RAM write port; contents survive reset, but a store seen during reset is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (!reset) begin
         if (ramWe_s) begin
            ram_r[ramIdx_s] <= WriteDataM;
         end
      end
   end

   // Cycle counter, timer compare and bus-error pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cycle_r    <= 64'h0;
         timecmp_r  <= 32'hFFFF_FFFF;
         timerIrq_r <= 1'b0;
         busError_r <= 1'b0;
      end else begin
         cycle_r    <= cycle_r + 64'd1;
         busError_r <= badAccess_s;
         // A TIMECMP write beats a match on the same edge.
         if (cmpWe_s) begin
            timecmp_r  <= WriteDataM;
            timerIrq_r <= 1'b0;
         end else if (cycle_r[31:0] == timecmp_r) begin
            timerIrq_r <= 1'b1;
         end
      end
   end

   // TX FIFO pointers, storage and registered head outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r    <= CNT_ZERO;
         rdPtr_r    <= '0;
         wrPtr_r    <= '0;
         overflow_r <= 1'b0;
         txValid_r  <= 1'b0;
         txData_r   <= 8'h00;
      end else begin
         if (accept_s) begin
            fifoMem_r[wrPtr_r] <= WriteDataM[7:0];
            wrPtr_r            <= wrPtr_r + PTR_ONE;
         end
         if (drop_s) begin
            overflow_r <= 1'b1;
         end
         rdPtr_r   <= rdPtrNext_s;
         count_r   <= countNext_s;
         txValid_r <= (countNext_s != CNT_ZERO);
         txData_r  <= headNext_s;
      end
   end

   assign ReadDataM = readData_s;
   assign tx_valid  = txValid_r;
   assign tx_data   = txData_r;
   assign timer_irq = timerIrq_r;
   assign bus_error = busError_r;

endmodule

// File: tb/tb_riscv_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_riscv_dmem_responder
//
// Directed scenarios followed by a randomized phase. Expected values come from
// a behavioural model: a word map for RAM, a byte queue for the TX FIFO and a
// plain edge counter for the cycle register.
// -----------------------------------------------------------------------------
module tb_riscv_dmem_responder;

   localparam int unsigned DEPTH_WORDS = 1024;
   localparam int unsigned FIFO_DEPTH  = 8;
   localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
   localparam logic [31:0] A_CLO       = MMIO_BASE;
   localparam logic [31:0] A_CHI       = MMIO_BASE + 32'd4;
   localparam logic [31:0] A_CMP       = MMIO_BASE + 32'd8;
   localparam logic [31:0] A_TX        = MMIO_BASE + 32'd12;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWriteM;
   logic [31:0] ALUResultM;
   logic [31:0] WriteDataM;
   logic [31:0] ReadDataM;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        timer_irq;
   logic        bus_error;

   always #5 clk = ~clk;

   riscv_dmem_responder #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .MMIO_BASE   (MMIO_BASE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .MemWriteM  (MemWriteM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .ReadDataM  (ReadDataM),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .timer_irq  (timer_irq),
      .bus_error  (bus_error)
   );

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   // reference model state
   logic [63:0] mCycle;
   logic [31:0] mCmp;
   logic        mIrq;
   logic        mOvf;
   logic        mBusErr;
   logic [7:0]  mFifo[$];
   logic [31:0] mRam[int];
   logic [7:0]  emitted[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected load value from the model; returns 0 if the RAM word was never written.
   function automatic bit expRead(input logic [31:0] a, output logic [31:0] v);
      logic [31:0] off;
      v   = 32'h0;
      off = a - MMIO_BASE;
      if (a[1:0] != 2'b00) return 1'b1;
      if (a < 32'(DEPTH_WORDS * 4)) begin
         if (mRam.exists(int'(a >> 2))) begin
            v = mRam[int'(a >> 2)];
            return 1'b1;
         end
         return 1'b0;
      end
      if (a >= MMIO_BASE && off < 32'd16) begin
         case (off)
            32'd0:   v = mCycle[31:0];
            32'd4:   v = mCycle[63:32];
            32'd8:   v = mCmp;
            32'd12:  v = {29'b0, mOvf, (mFifo.size() == FIFO_DEPTH), (mFifo.size() == 0)};
            default: v = 32'h0;
         endcase
      end
      return 1'b1;
   endfunction

   task automatic modelReset();
      mCycle  = 64'h0;
      mCmp    = 32'hFFFF_FFFF;
      mIrq    = 1'b0;
      mOvf    = 1'b0;
      mBusErr = 1'b0;
      mFifo.delete();
      emitted.delete();
   endtask

   task automatic doReset();
      reset      = 1'b1;
      MemWriteM  = 1'b0;
      ALUResultM = 32'h0;
      WriteDataM = 32'h0;
      tx_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      modelReset();
   endtask

   // One bus cycle: drive, check the load, clock, advance the model, check outputs.
   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
      logic [31:0] ev;
      logic [31:0] off;
      bit known, inRam, inMmio, aligned, bad, pop, push;
      MemWriteM  = we;
      ALUResultM = a;
      WriteDataM = d;
      tx_ready   = rdy;
      #1;
      known = expRead(a, ev);
      if (known) check("ReadDataM", {32'h0, ReadDataM}, {32'h0, ev});
      if (tx_valid && rdy) emitted.push_back(tx_data);
      @(posedge clk);
      off     = a - MMIO_BASE;
      aligned = (a[1:0] == 2'b00);
      inRam   = (a < 32'(DEPTH_WORDS * 4));
      inMmio  = !inRam && (a >= MMIO_BASE) && (off < 32'd16);
      bad     = !aligned || (we && !inRam && !inMmio);
      pop     = (mFifo.size() != 0) && rdy;
      push    = we && aligned && inMmio && (off == 32'd12);
      if (push && mFifo.size() == FIFO_DEPTH && !pop) mOvf = 1'b1;
      if (pop) void'(mFifo.pop_front());
      if (push && mFifo.size() < FIFO_DEPTH) mFifo.push_back(d[7:0]);
      if (we && aligned && inRam) mRam[int'(a >> 2)] = d;
      if (we && aligned && inMmio && off == 32'd8) begin
         mCmp = d;
         mIrq = 1'b0;
      end else if (mCycle[31:0] == mCmp) begin
         mIrq = 1'b1;
      end
      mCycle  = mCycle + 64'd1;
      mBusErr = bad;
      #1;
      check("tx_valid",  {63'h0, tx_valid},  {63'h0, (mFifo.size() != 0)});
      check("tx_data",   {56'h0, tx_data},   {56'h0, (mFifo.size() != 0) ? mFifo[0] : 8'h00});
      check("timer_irq", {63'h0, timer_irq}, {63'h0, mIrq});
      check("bus_error", {63'h0, bus_error}, {63'h0, mBusErr});
   endtask

   // Combinational load check without a clock edge.
   task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
      MemWriteM  = 1'b0;
      ALUResultM = a;
      #1;
      check(tag, {32'h0, ReadDataM}, {32'h0, exp});
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 32'h0, 32'h0, rdy);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] c;
      logic [31:0] a;
      logic [31:0] d;
      int          riseAt;
      int unsigned sel;

      // ---------------- power-up reset values ----------------
      reset      = 1'b1;
      MemWriteM  = 1'b0;
      ALUResultM = A_CLO;
      WriteDataM = 32'h0;
      tx_ready   = 1'b0;
      #1;
      check("rst_tx_valid",  {63'h0, tx_valid},  64'h0);
      check("rst_tx_data",   {56'h0, tx_data},   64'h0);
      check("rst_timer_irq", {63'h0, timer_irq}, 64'h0);
      check("rst_bus_error", {63'h0, bus_error}, 64'h0);
      check("rst_cycle_lo",  {32'h0, ReadDataM}, 64'h0);
      peek("rst_status",  A_TX,  32'h0000_0001);
      peek("rst_timecmp", A_CMP, 32'hFFFF_FFFF);
      doReset();

      // ---------------- RAM store / load ----------------
      step(1'b1, 32'h14, 32'h1234_5678, 1'b0);
      step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
      peek("ram_0x10", 32'h10, 32'hDEAD_BEEF);
      peek("ram_0x14", 32'h14, 32'h1234_5678);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2, $urandom, 1'b0);
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 32'($urandom_range(0, DEPTH_WORDS - 1)) << 2, 32'h0, 1'b0);
      end

      // ---------------- TX overflow then drain ----------------
      for (int i = 0; i < 9; i++) begin
         step(1'b1, A_TX, 32'h41 + 32'(i), 1'b0);
      end
      peek("tx_status_ovf_full", A_TX, 32'h0000_0006);
      for (int i = 0; i < 10; i++) idle(1'b1);
      check("tx_emit_count", 64'(emitted.size()), 64'd8);
      for (int i = 0; i < 8 && i < emitted.size(); i++) begin
         check("tx_emit_byte", {56'h0, emitted[i]}, 64'h41 + 64'(i));
      end
      peek("tx_status_ovf_empty", A_TX, 32'h0000_0005);

      // ---------------- push into full FIFO with pop ----------------
      doReset();
      for (int i = 0; i < 8; i++) step(1'b1, A_TX, 32'h60 + 32'(i), 1'b0);
      step(1'b1, A_TX, 32'h99, 1'b1);
      peek("tx_full_push_pop", A_TX, 32'h0000_0002);
      for (int i = 0; i < 10; i++) idle(1'b1);
      check("tx_full_emit_count", 64'(emitted.size()), 64'd9);
      if (emitted.size() != 0) check("tx_full_last", {56'h0, emitted[emitted.size() - 1]}, 64'h99);

      // ---------------- timer compare ----------------
      c = mCycle[31:0];
      step(1'b1, A_CMP, c + 32'd20, 1'b0);
      riseAt = -1;
      for (int k = 1; k <= 30; k++) begin
         idle(1'b0);
         if (timer_irq && riseAt < 0) riseAt = k;
      end
      check("irq_rise_edges", 64'(riseAt), 64'd20);
      step(1'b1, A_CMP, 32'hFFFF_FFF0, 1'b0);
      check("irq_cleared", {63'h0, timer_irq}, 64'h0);
      c = mCycle[31:0];
      step(1'b1, A_CMP, c + 32'd3, 1'b0);
      idle(1'b0);
      idle(1'b0);
      step(1'b1, A_CMP, 32'hFFFF_FFF0, 1'b0);
      check("irq_write_wins", {63'h0, timer_irq}, 64'h0);
      step(1'b1, A_CLO, 32'h1111_1111, 1'b0);
      check("ro_write_no_err", {63'h0, bus_error}, 64'h0);

      // ---------------- bus errors ----------------
      step(1'b1, 32'h0, 32'h5A5A_0000, 1'b0);
      step(1'b1, 32'h0000_0002, 32'hCAFE_F00D, 1'b0);
      check("berr_misaligned", {63'h0, bus_error}, 64'h1);
      peek("berr_mis_rdata", 32'h0000_0002, 32'h0);
      peek("berr_ram_kept", 32'h0, 32'h5A5A_0000);
      step(1'b1, 32'h4000_0000, 32'hCAFE_F00D, 1'b0);
      check("berr_unmapped", {63'h0, bus_error}, 64'h1);
      peek("berr_unm_rdata", 32'h4000_0000, 32'h0);
      idle(1'b0);
      check("berr_pulse_end", {63'h0, bus_error}, 64'h0);
      step(1'b0, 32'h0000_0013, 32'h0, 1'b0);
      check("berr_mis_read", {63'h0, bus_error}, 64'h1);

      // ---------------- asynchronous reset mid-drain ----------------
      step(1'b1, 32'h20, 32'h1111_2222, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, A_TX, 32'hA0 + 32'(i), 1'b0);
      c = mCycle[31:0];
      step(1'b1, A_CMP, c + 32'd2, 1'b0);
      for (int i = 0; i < 3; i++) idle(1'b1);
      check("pre_rst_irq",   {63'h0, timer_irq}, 64'h1);
      check("pre_rst_valid", {63'h0, tx_valid},  64'h1);
      MemWriteM  = 1'b0;
      ALUResultM = A_CLO;
      #2;
      reset = 1'b1;
      #1;
      check("arst_tx_valid",  {63'h0, tx_valid},  64'h0);
      check("arst_tx_data",   {56'h0, tx_data},   64'h0);
      check("arst_timer_irq", {63'h0, timer_irq}, 64'h0);
      check("arst_cycle_lo",  {32'h0, ReadDataM}, 64'h0);
      MemWriteM  = 1'b1;
      ALUResultM = 32'h20;
      WriteDataM = 32'hBAD0_BAD0;
      @(posedge clk);
      #1;
      MemWriteM = 1'b0;
      reset     = 1'b0;
      modelReset();
      peek("arst_store_lost", 32'h20, 32'h1111_2222);

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 9);
         d   = $urandom;
         case (sel)
            0, 1, 2, 3: a = 32'($urandom_range(0, 63)) << 2;
            4:          a = ($urandom_range(0, 1) == 0) ? A_CLO : A_CHI;
            5: begin
               a = A_CMP;
               d = mCycle[31:0] + 32'($urandom_range(0, 6));
            end
            6, 7:       a = A_TX;
            8:          a = 32'h4000_0000 + (32'($urandom_range(0, 255)) << 2);
            default:    a = (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
         endcase
         step(1'($urandom_range(0, 1)), a, d, 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
